// File: rtl/dwell_driver.sv
// Purpose : dwell-time-limited level driver; each sig_out transition is followed by a hold of max(dwell,1) cycles.
// Latency : accepted level change or force_safe appears on sig_out at the next rising clk edge.
// Backpres: req_ready low while holding, under force_safe, or before the run flag; requester holds req_valid/req_level.
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   req_valid/req_level  level request; accepted when req_ready is also high
//   req_ready            combinational accept qualifier
//   dwell                minimum hold after a transition (0 treated as 1), sampled at the transition edge
//   force_safe           drives sig_out to SAFE_LEVEL, overriding any request
//   sig_out              registered driven signal
//   busy                 high while in HOLD
//   trans_cnt            wrapping count of sig_out transitions

module dwell_driver #(
  parameter int   CNT_BITS   = 16,
  parameter logic SAFE_LEVEL = 1'b0,
  parameter int   TCNT_BITS  = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 req_valid,
  input  logic                 req_level,
  output logic                 req_ready,
  input  logic [CNT_BITS-1:0]  dwell,
  input  logic                 force_safe,
  output logic                 sig_out,
  output logic                 busy,
  output logic [TCNT_BITS-1:0] trans_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [CNT_BITS-1:0]  CNT_ONE  = {{(CNT_BITS-1){1'b0}}, 1'b1};
  localparam logic [TCNT_BITS-1:0] TCNT_ONE = {{(TCNT_BITS-1){1'b0}}, 1'b1};

  state_t              state;
  logic [CNT_BITS-1:0] cnt;
  logic                run;

  logic [CNT_BITS-1:0] hold_load;
  logic                accept;
  logic                cnt_zero;

  // cnt is loaded with D-1 where D = max(dwell,1), so dwell=0 and dwell=1
  // both load zero and allow a new transition on the very next edge.
  assign hold_load = (dwell == '0) ? '0 : (dwell - CNT_ONE);
  assign cnt_zero  = (cnt == '0);

  // A hold whose counter has reached zero may already accept, which is what
  // lets back-to-back transitions land exactly every D edges.
  assign req_ready = run && !force_safe && ((state == IDLE) || cnt_zero);
  assign accept    = req_valid && req_ready;
  assign busy      = (state == HOLD);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      run       <= 1'b0;
      sig_out   <= SAFE_LEVEL;
      trans_cnt <= '0;
    end else begin
      run <= 1'b1;

      if (force_safe) begin
        if (sig_out != SAFE_LEVEL) begin
          // Safe transition ignores any hold in progress and starts a new one.
          sig_out   <= SAFE_LEVEL;
          cnt       <= hold_load;
          state     <= HOLD;
          trans_cnt <= trans_cnt + TCNT_ONE;
        end else if (state == HOLD) begin
          // Already safe: let the current hold run out normally.
          if (!cnt_zero) begin
            cnt <= cnt - CNT_ONE;
          end else begin
            state <= IDLE;
          end
        end
      end else if (accept) begin
        if (req_level != sig_out) begin
          sig_out   <= req_level;
          cnt       <= hold_load;
          state     <= HOLD;
          trans_cnt <= trans_cnt + TCNT_ONE;
        end else begin
          // Request for the current level is consumed without starting a hold.
          state <= IDLE;
        end
      end else if (state == HOLD) begin
        if (!cnt_zero) begin
          cnt <= cnt - CNT_ONE;
        end else begin
          state <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_dwell_driver.sv
// Purpose : directed self-checking bench for dwell_driver (TCNT_BITS=4 so counter wrap is reachable).
// Latency : expectations sampled 1 time unit after each rising edge.
// Backpres: request inputs are held while req_ready is low, as a real requester would.

module tb_dwell_driver;

  logic        clk;
  logic        rstn;
  logic        req_valid;
  logic        req_level;
  logic        req_ready;
  logic [15:0] dwell;
  logic        force_safe;
  logic        sig_out;
  logic        busy;
  logic [3:0]  trans_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  dwell_driver #(
    .CNT_BITS   (16),
    .SAFE_LEVEL (1'b0),
    .TCNT_BITS  (4)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_level  (req_level),
    .req_ready  (req_ready),
    .dwell      (dwell),
    .force_safe (force_safe),
    .sig_out    (sig_out),
    .busy       (busy),
    .trans_cnt  (trans_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic       lvl;
    logic [3:0] tc;

    rstn       = 1'b0;
    req_valid  = 1'b1;
    req_level  = 1'b1;
    dwell      = 16'd4;
    force_safe = 1'b0;

    // Reset state
    #2;
    check("rst_sig_out",   sig_out,   1'b0);
    check("rst_busy",      busy,      1'b0);
    check("rst_trans_cnt", trans_cnt, 4'd0);
    check("rst_ready",     req_ready, 1'b0);

    // Release reset between edges; run flag sets on the next edge
    step();
    rstn = 1'b1;
    #1;
    check("cyc1_ready", req_ready, 1'b0);
    step();
    check("cyc2_ready", req_ready, 1'b1);
    check("cyc2_sig",   sig_out,   1'b0);
    step();
    check("first_sig",   sig_out,   1'b1);
    check("first_busy",  busy,      1'b1);
    check("first_tc",    trans_cnt, 4'd1);
    check("first_ready", req_ready, 1'b0);

    // dwell=4: alternate requests, toggle every 4 edges
    lvl = 1'b1;
    tc  = 4'd1;
    for (int t = 0; t < 3; t++) begin
      req_level = ~lvl;
      for (int e = 1; e <= 3; e++) begin
        step();
        check("d4_hold_sig",   sig_out,   lvl);
        check("d4_hold_ready", req_ready, (e == 3));
      end
      step();
      lvl = ~lvl;
      tc  = tc + 4'd1;
      check("d4_tog_sig",   sig_out,   lvl);
      check("d4_tog_tc",    trans_cnt, tc);
      check("d4_tog_busy",  busy,      1'b1);
      check("d4_tog_ready", req_ready, 1'b0);
    end

    // Request equal to current level (0): consumed, no toggle, no hold
    req_level = lvl;
    for (int e = 1; e <= 3; e++) step();
    check("eq_ready_at_cnt0", req_ready, 1'b1);
    step();
    check("eq_busy", busy,      1'b0);
    check("eq_sig",  sig_out,   1'b0);
    check("eq_tc",   trans_cnt, tc);
    step();
    check("eq_idle_busy",  busy,      1'b0);
    check("eq_idle_ready", req_ready, 1'b1);
    check("eq_idle_tc",    trans_cnt, tc);

    // dwell=0: toggle every edge, busy high, ready always high
    dwell = 16'd0;
    for (int t = 0; t < 6; t++) begin
      req_level = ~lvl;
      #1;
      check("d0_ready_pre", req_ready, 1'b1);
      step();
      lvl = ~lvl;
      tc  = tc + 4'd1;
      check("d0_sig",   sig_out,   lvl);
      check("d0_busy",  busy,      1'b1);
      check("d0_ready", req_ready, 1'b1);
      check("d0_tc",    trans_cnt, tc);
    end

    // force_safe mid-hold at level 1 with cnt=5 (dwell=8)
    dwell     = 16'd8;
    req_level = 1'b1;
    step();
    lvl = 1'b1;
    tc  = tc + 4'd1;
    check("fs_pre_sig", sig_out,   1'b1);
    check("fs_pre_tc",  trans_cnt, tc);
    step();
    step();
    check("fs_pre_busy",  busy,      1'b1);
    check("fs_pre_ready", req_ready, 1'b0);
    force_safe = 1'b1;
    req_level  = 1'b0;
    #1;
    check("fs_ready_low", req_ready, 1'b0);
    step();
    force_safe = 1'b0;
    req_level  = 1'b1;
    lvl = 1'b0;
    tc  = tc + 4'd1;
    check("fs_sig",  sig_out,   1'b0);
    check("fs_tc",   trans_cnt, tc);
    check("fs_busy", busy,      1'b1);
    // Reloaded to 7: ready reappears after 7 edges; a dwell change mid-hold is ignored
    for (int e = 1; e <= 7; e++) begin
      step();
      if (e == 1) dwell = 16'd2;
      check("fs_hold_sig",   sig_out,   1'b0);
      check("fs_hold_ready", req_ready, (e == 7));
    end
    step();
    lvl = 1'b1;
    tc  = tc + 4'd1;
    check("post_fs_sig", sig_out,   1'b1);
    check("post_fs_tc",  trans_cnt, tc);

    // dwell=2: finish out to 16 toggles so trans_cnt wraps to 0
    for (int t = 0; t < 3; t++) begin
      req_level = ~lvl;
      step();
      check("d2_ready", req_ready, 1'b1);
      check("d2_sig",   sig_out,   lvl);
      step();
      lvl = ~lvl;
      tc  = tc + 4'd1;
      check("d2_sig_tog", sig_out, lvl);
    end
    check("wrap_tc", trans_cnt, 4'd0);

    // force_safe while already safe: no toggle, hold runs out, then IDLE
    force_safe = 1'b1;
    req_level  = 1'b1;
    step();
    check("fs_safe_sig",   sig_out,   1'b0);
    check("fs_safe_tc",    trans_cnt, 4'd0);
    check("fs_safe_busy",  busy,      1'b1);
    check("fs_safe_ready", req_ready, 1'b0);
    step();
    check("fs_safe_idle", busy,      1'b0);
    check("fs_safe_sig2", sig_out,   1'b0);
    force_safe = 1'b0;
    #1;
    check("fs_release_ready", req_ready, 1'b1);

    // Asynchronous reset mid-hold at level 1
    dwell = 16'd8;
    step();
    check("ar_sig_pre",  sig_out,   1'b1);
    check("ar_busy_pre", busy,      1'b1);
    check("ar_tc_pre",   trans_cnt, 4'd1);
    step();
    #2;
    rstn = 1'b0;
    #1;
    check("ar_sig",   sig_out,   1'b0);
    check("ar_busy",  busy,      1'b0);
    check("ar_tc",    trans_cnt, 4'd0);
    check("ar_ready", req_ready, 1'b0);
    #1;
    rstn = 1'b1;
    step();
    check("ar_rel_sig", sig_out, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
